piso_reg_4b: RTL and testbench
==============================

# piso_reg_4b

Parallel-in/serial-out shift register modelled on the 74HC165, fully synchronous to one clock. A parallel word is captured on a load command, then shifted out MSB-first on the serial output, one bit per enabled clock edge, while a serial input fills the vacated LSB. It sits between a parallel data source (switch bank, bus latch) and a serial consumer, with complementary serial outputs for daisy-chaining or differential use.

## Interface
- WIDTH, 8, register length in bits; D_in width. Minimum 2.

- clk  input  1  system clock; all state changes on rising edge.
- rst_n  input  1  reset, synchronous and active-low; sampled on rising clk.
- clken  input  1  clock inhibit, 74HC165 CLK INH semantics: 1 = hold, 0 = shift enabled.
- LOAD  input  1  shift/load select, active-low: 0 = parallel load, 1 = shift/hold.
- D_in  input  WIDTH  parallel data word; D_in[WIDTH-1] is the first bit out.
- SER  input  1  serial data in; enters at bit 0 on each shift.
- Q  output  1  serial out = register bit WIDTH-1 (74HC165 QH).
- QNEG  output  1  always the complement of Q (74HC165 QH').

## Operation
- Internal state: one WIDTH-bit register r. No other state, no FSM.
- Per rising clk edge, priority order:
  1. rst_n = 0: r <= 0.
  2. LOAD = 0: r <= D_in. Load is synchronous and overrides clken; clken is ignored.
  3. clken = 0: shift, r <= {r[WIDTH-2:0], SER}.
  4. Otherwise hold, r unchanged.
- Q = r[WIDTH-1], QNEG = ~r[WIDTH-1]. Both are driven combinationally from r only, so they are glitch-free with respect to inputs.
- Loading while a shift is in progress discards the remaining bits. The new word is visible immediately after the load edge.
- Holding LOAD low for several edges reloads D_in on each edge. The last sampled D_in wins.
- After WIDTH shifts, r holds the last WIDTH SER samples. Chaining works by feeding Q of one stage into SER of the next.
- X/undriven D_in or SER must not corrupt r unless that input is actually sampled.

## Timing
- Reset values: r = 0, Q = 0, QNEG = 1, all valid after the first rising edge with rst_n = 0.
- Load latency is 1 edge. After the load edge, Q = D_in[WIDTH-1].
- Shift latency is 1 edge per bit. Bit D_in[WIDTH-1-k] appears on Q after the k-th enabled shift edge following the load, for k = 0..WIDTH-1.
- The SER value sampled at shift edge j appears on Q after WIDTH-1 further shift edges (j + WIDTH-1 in total).
- A clken change takes effect on the next edge. There is no partial-cycle behaviour.
- Reset asserted mid-shift clears r on that edge, overriding LOAD.
- Simultaneous LOAD = 0 and clken = 0: load wins.

## Test plan
- Reset: rst_n = 0 for 1 edge with LOAD = 0 and D_in = 8'hFF -> Q = 0 and QNEG = 1 after the edge.
- Load/shift: with SER = 0, load 8'hAB (LOAD = 0, clken = 1). Then LOAD = 1 for 1 held edge, then clken = 0 for 9 edges -> Q is 1 after the load and unchanged after the hold edge. Over the shift edges Q reads 0,1,0,1,0,1,1, then 0,0, and QNEG = ~Q at every sample.
- Hold: load 8'h66, shift 4 edges, then clken = 1 for 1 edge, then clken = 0 -> Q sequence 0,1,1,0,0, the value 0 held over the inhibit edge, then 1,1,0.
- Serial fill: load 8'h97, shift 8 edges with SER = 0 -> Q = 1,0,0,1,0,1,1,1 across the load and shift edges, then 0. Then set SER = 1 and shift 8 more edges -> Q goes to 1 on the 8th and stays 1.
- Load override: mid-shift, assert LOAD = 0 with clken = 0 and D_in = 8'h80 -> Q = 1 on that edge, with no shift applied.
- Reset mid-shift: after loading 8'hFF, assert rst_n = 0 with LOAD = 0 -> Q = 0 and QNEG = 1 on that edge.

Source files
------------

// File: rtl/piso_reg_4b.sv
// Parallel-in/serial-out shift register in the style of the 74HC165, fully synchronous.
// The word loads on LOAD=0 and shifts out MSB-first on each edge with clken=0; SER fills the LSB.
module piso_reg_4b #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clken,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] D_in,
  input  logic             SER,
  output logic             Q,
  output logic             QNEG
);

  if (WIDTH < 2) begin : g_width_check
    $error("piso_reg_4b: WIDTH must be at least 2");
  end

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_d;

  // Load beats shift, and shift beats hold. Each input is read only on the branch that samples it.
  always_comb begin
    r_d = r_q;
    if (!LOAD) begin
      r_d = D_in;
    end else if (!clken) begin
      r_d = {r_q[WIDTH-2:0], SER};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_q <= '0;
    end else begin
      r_q <= r_d;
    end
  end

  assign Q    = r_q[WIDTH-1];
  assign QNEG = ~r_q[WIDTH-1];

endmodule

// File: tb/tb_piso_reg_4b.sv
// Self-checking bench for piso_reg_4b: directed serial sequences plus randomized traffic
// compared against an arithmetic model of the register word.
module tb_piso_reg_4b;

  localparam int unsigned WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic             clken;
  logic             LOAD;
  logic [WIDTH-1:0] D_in;
  logic             SER;
  logic             Q;
  logic             QNEG;

  int n_tests;
  int n_fail;

  piso_reg_4b #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clken (clken),
    .LOAD  (LOAD),
    .D_in  (D_in),
    .SER   (SER),
    .Q     (Q),
    .QNEG  (QNEG)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge; outputs are then sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One load edge: LOAD=0, clken left inhibited.
  task automatic do_load(input logic [WIDTH-1:0] word);
    LOAD  = 1'b0;
    clken = 1'b1;
    D_in  = word;
    tick();
    LOAD  = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    LOAD  = 1'b0;
    clken = 1'b1;
    D_in  = 8'hFF;
    SER   = 1'b1;
    tick();
    n_tests++;
    if (Q !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_q: Q=%b expected 0", Q);
    end
    n_tests++;
    if (QNEG !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_qneg: QNEG=%b expected 1", QNEG);
    end
    rst_n = 1'b1;
    LOAD  = 1'b1;
  endtask

  task automatic test_load_shift();
    bit exp_seq [0:8];
    exp_seq = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    SER = 1'b0;
    do_load(8'hAB);
    n_tests++;
    if (Q !== 1'b1) begin
      n_fail++;
      $display("FAIL load_ab: Q=%b expected 1", Q);
    end
    tick();
    n_tests++;
    if (Q !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_after_load: Q=%b expected 1", Q);
    end
    clken = 1'b0;
    for (int k = 0; k < 9; k++) begin
      tick();
      n_tests++;
      if (Q !== exp_seq[k] || QNEG !== ~exp_seq[k]) begin
        n_fail++;
        $display("FAIL shift_ab[%0d]: Q=%b QNEG=%b expected Q=%b QNEG=%b",
                 k, Q, QNEG, exp_seq[k], ~exp_seq[k]);
      end
    end
    clken = 1'b1;
  endtask

  task automatic test_hold();
    bit exp_seq [0:7];
    bit en_seq  [0:7];
    exp_seq = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    en_seq  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    SER = 1'b0;
    do_load(8'h66);
    n_tests++;
    if (Q !== 1'b0) begin
      n_fail++;
      $display("FAIL load_66: Q=%b expected 0", Q);
    end
    for (int k = 0; k < 8; k++) begin
      clken = en_seq[k];
      tick();
      n_tests++;
      if (Q !== exp_seq[k]) begin
        n_fail++;
        $display("FAIL hold_seq[%0d]: Q=%b expected %b", k, Q, exp_seq[k]);
      end
    end
    clken = 1'b1;
  endtask

  task automatic test_serial_fill();
    logic [WIDTH-1:0] word;
    word = 8'h97;
    SER  = 1'b0;
    do_load(word);
    n_tests++;
    if (Q !== word[7]) begin
      n_fail++;
      $display("FAIL load_97: Q=%b expected %b", Q, word[7]);
    end
    clken = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      n_tests++;
      if (Q !== ((k < 8) ? word[7-k] : 1'b0)) begin
        n_fail++;
        $display("FAIL fill_drain[%0d]: Q=%b expected %b", k, Q, (k < 8) ? word[7-k] : 1'b0);
      end
    end
    SER = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      n_tests++;
      if (Q !== (k >= 8)) begin
        n_fail++;
        $display("FAIL fill_ser1[%0d]: Q=%b expected %b", k, Q, k >= 8);
      end
    end
    clken = 1'b1;
  endtask

  task automatic test_load_override();
    SER = 1'b1;
    do_load(8'hAB);
    clken = 1'b0;
    repeat (3) tick();
    n_tests++;
    if (Q !== 1'b0) begin
      n_fail++;
      $display("FAIL override_pre: Q=%b expected 0", Q);
    end
    LOAD = 1'b0;
    D_in = 8'h80;
    tick();
    n_tests++;
    if (Q !== 1'b1 || QNEG !== 1'b0) begin
      n_fail++;
      $display("FAIL override_load: Q=%b QNEG=%b expected Q=1 QNEG=0", Q, QNEG);
    end
    // If a shift had also been applied the ones from SER would show up on Q within 7 shifts.
    LOAD = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      tick();
      n_tests++;
      if (Q !== 1'b0) begin
        n_fail++;
        $display("FAIL override_tail[%0d]: Q=%b expected 0", k, Q);
      end
    end
    clken = 1'b1;
  endtask

  task automatic test_reset_mid_shift();
    SER = 1'b1;
    do_load(8'hFF);
    clken = 1'b0;
    repeat (2) tick();
    rst_n = 1'b0;
    LOAD  = 1'b0;
    D_in  = 8'hFF;
    tick();
    n_tests++;
    if (Q !== 1'b0 || QNEG !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid: Q=%b QNEG=%b expected Q=0 QNEG=1", Q, QNEG);
    end
    rst_n = 1'b1;
    LOAD  = 1'b1;
    SER   = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      n_tests++;
      if (Q !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_mid_drain[%0d]: Q=%b expected 0", k, Q);
      end
    end
    clken = 1'b1;
  endtask

  // Unsampled X inputs must never reach the register.
  task automatic test_x_isolation();
    int unsigned m;
    m = 32'h5A;
    SER = 1'b0;
    do_load(8'h5A);
    D_in  = 'x;
    SER   = 1'bx;
    clken = 1'b1;
    repeat (3) tick();
    n_tests++;
    if (Q !== 1'b0) begin
      n_fail++;
      $display("FAIL x_hold: Q=%b expected 0", Q);
    end
    clken = 1'b0;
    for (int k = 0; k < 8; k++) begin
      SER = 1'($urandom_range(1));
      m   = ((m * 2) + SER) % 256;
      tick();
      n_tests++;
      if (Q !== 1'(m / 128)) begin
        n_fail++;
        $display("FAIL x_shift[%0d]: Q=%b expected %b", k, Q, 1'(m / 128));
      end
    end
    clken = 1'b1;
    D_in  = '0;
  endtask

  task automatic test_random();
    int unsigned m;
    logic        exp_q;
    m = 0;
    rst_n = 1'b0;
    LOAD  = 1'b1;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 500; i++) begin
      rst_n = ($urandom_range(31) != 0);
      LOAD  = ($urandom_range(5) != 0);
      clken = ($urandom_range(3) == 0);
      D_in  = 8'($urandom);
      SER   = 1'($urandom_range(1));
      if (!rst_n)      m = 0;
      else if (!LOAD)  m = int'(D_in);
      else if (!clken) m = ((m * 2) + SER) % 256;
      exp_q = 1'(m / 128);
      tick();
      n_tests++;
      if (Q !== exp_q || QNEG !== ~exp_q) begin
        n_fail++;
        $display("FAIL random[%0d]: Q=%b QNEG=%b expected Q=%b QNEG=%b",
                 i, Q, QNEG, exp_q, ~exp_q);
      end
    end
    rst_n = 1'b1;
    LOAD  = 1'b1;
    clken = 1'b1;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    clken   = 1'b1;
    LOAD    = 1'b1;
    D_in    = '0;
    SER     = 1'b0;
    #2;
    test_reset();
    test_load_shift();
    test_hold();
    test_serial_fill();
    test_load_override();
    test_reset_mid_shift();
    test_x_isolation();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
